// File: rtl/transmitter_pkg.sv
// Shared transmitter/receiver definitions: frame header, frame length,
// STATUS byte layout and the transmit FSM state encoding.
package transmitter_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam int STATUS_ERR = 7;
  localparam int STATUS_OVR = 6;
  localparam int SEQ_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    SEND
  } tx_state_t;

  function automatic int frame_len(input int num_channels);
    return num_channels + 3;
  endfunction

  function automatic logic [7:0] status_byte(
    input logic             err,
    input logic             ovr,
    input logic [SEQ_W-1:0] seq
  );
    logic [7:0] s;
    s             = '0;
    s[STATUS_ERR] = err;
    s[STATUS_OVR] = ovr;
    s[SEQ_W-1:0]  = seq;
    return s;
  endfunction

endpackage

// File: rtl/transmitter_frame_builder.sv
// Combinational frame byte mux: snapshot registers + byte index -> byte.
// Ports: phases/err/ovr/seq (snapshot), idx (byte index), data (frame byte).
module frame_builder
  import transmitter_pkg::*;
#(
  parameter int         NUM_CHANNELS = 2,
  parameter int         PHASE_W      = 8,
  parameter int         DATA_W       = 8,
  parameter logic [7:0] HEADER       = HEADER_BYTE,
  parameter int         IDX_W        = 3
) (
  input  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
  input  logic                                 err,
  input  logic                                 ovr,
  input  logic [SEQ_W-1:0]                     seq,
  input  logic [IDX_W-1:0]                     idx,
  output logic [DATA_W-1:0]                    data
);

  localparam int FRAME_LEN = frame_len(NUM_CHANNELS);

  logic [DATA_W-1:0] body [FRAME_LEN-1];
  logic [DATA_W-1:0] csum;

  always_comb begin
    body[0] = DATA_W'(HEADER);
    body[1] = DATA_W'(status_byte(err, ovr, seq));
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      body[i+2] = DATA_W'(phases[i]);
    end
  end

  always_comb begin
    csum = '0;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      csum = csum ^ body[i];
    end
  end

  // Checksum is the default; any body index overrides it.
  always_comb begin
    data = csum;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      if (idx == IDX_W'(i)) data = body[i];
    end
  end

endmodule

// File: rtl/transmitter.sv
// Status frame transmitter: snapshots phases/error on request and writes
// a checksummed frame into the TX FIFO. Ports: send_req, phases,
// read_error, txfifo_load/full in; txfifo_wr/data, busy out.
module transmitter
  import transmitter_pkg::*;
#(
  parameter int         NUM_CHANNELS   = 2,
  parameter int         PHASE_W        = 8,
  parameter int         DATA_W         = 8,
  parameter int         TX_FIFO_SIZE   = 4096,
  parameter int         TX_FIFO_LOAD_W = 13,
  parameter logic [7:0] HEADER         = HEADER_BYTE
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 send_req,
  input  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
  input  logic                                 read_error,
  input  logic [TX_FIFO_LOAD_W-1:0]            txfifo_load,
  input  logic                                 txfifo_full,
  output logic                                 txfifo_wr,
  output logic [DATA_W-1:0]                    txfifo_data,
  output logic                                 busy
);

  localparam int FRAME_LEN = frame_len(NUM_CHANNELS);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int SUM_W     = TX_FIFO_LOAD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tx_state_t state;
  tx_state_t state_nxt;

  logic [IDX_W-1:0]                     idx;
  logic [SEQ_W-1:0]                     seq;
  logic                                 pending;
  logic                                 ovr;
  logic                                 snap_err;
  logic                                 snap_ovr;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] snap_phases;

  logic [SUM_W-1:0]  fill;
  logic              space_ok;
  logic              take;
  logic              fire;
  logic              last;
  logic [DATA_W-1:0] frame_byte;

  // One extra bit so load + FRAME_LEN cannot wrap.
  assign fill     = {1'b0, txfifo_load} + SUM_W'(FRAME_LEN);
  assign space_ok = fill <= SUM_W'(TX_FIFO_SIZE);

  assign take = (state == IDLE) & (send_req | pending);
  assign fire = (state == SEND) & ~txfifo_full;
  assign last = fire & (idx == LAST_IDX);

  assign busy        = (state != IDLE);
  assign txfifo_wr   = fire;
  assign txfifo_data = busy ? frame_byte : '0;

  frame_builder #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PHASE_W      (PHASE_W),
    .DATA_W       (DATA_W),
    .HEADER       (HEADER),
    .IDX_W        (IDX_W)
  ) u_builder (
    .phases (snap_phases),
    .err    (snap_err),
    .ovr    (snap_ovr),
    .seq    (seq),
    .idx    (idx),
    .data   (frame_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (take) state_nxt = space_ok ? SEND : WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (space_ok) state_nxt = SEND;
      end
      SEND: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      seq         <= '0;
      pending     <= 1'b0;
      ovr         <= 1'b0;
      snap_err    <= 1'b0;
      snap_ovr    <= 1'b0;
      snap_phases <= '0;
    end else begin
      if (fire) idx <= last ? '0 : idx + 1'b1;
      if (last) seq <= seq + 1'b1;
      // A request coinciding with the snapshot is absorbed by it.
      if (take) begin
        snap_phases <= phases;
        snap_err    <= read_error;
        snap_ovr    <= ovr;
        pending     <= 1'b0;
        ovr         <= 1'b0;
      end else if (busy && send_req) begin
        if (pending) ovr <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: expected frame bytes are queued as
// requests are issued; a negedge monitor pops and compares on each write.
module tb_transmitter;

  logic            clk = 1'b0;
  logic            rst;
  logic            send_req;
  logic [1:0][7:0] phases;
  logic            read_error;
  logic [12:0]     txfifo_load;
  logic            txfifo_full;
  logic            txfifo_wr;
  logic [7:0]      txfifo_data;
  logic            busy;

  transmitter dut (
    .clk         (clk),
    .rst         (rst),
    .send_req    (send_req),
    .phases      (phases),
    .read_error  (read_error),
    .txfifo_load (txfifo_load),
    .txfifo_full (txfifo_full),
    .txfifo_wr   (txfifo_wr),
    .txfifo_data (txfifo_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] expq [$];
  int         wr_cyc [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && txfifo_wr) begin
      wr_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got %h expected no write",
                 txfifo_data);
      end else begin
        check("frame_byte", {24'h0, txfifo_data}, {24'h0, expq.pop_front()});
      end
    end
  end

  task automatic push5(input logic [7:0] a, b, c, d, e);
    expq.push_back(a);
    expq.push_back(b);
    expq.push_back(c);
    expq.push_back(d);
    expq.push_back(e);
  endtask

  task automatic send_pulse(output int k);
    @(posedge clk);
    #1 send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    check("busy_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic check_frame(input string nm, input int first,
                             input int span);
    check({nm, "_nwr"}, wr_cyc.size(), 5);
    if (wr_cyc.size() == 5) begin
      check({nm, "_first"}, wr_cyc[0], first);
      check({nm, "_span"}, wr_cyc[4] - wr_cyc[0], span);
    end
  endtask

  int k;
  int p;

  initial begin
    rst         = 1'b1;
    send_req    = 1'b0;
    phases      = {8'h20, 8'h10};
    read_error  = 1'b0;
    txfifo_load = '0;
    txfifo_full = 1'b0;
    #1;
    check("rst_wr", {31'h0, txfifo_wr}, 32'h0);
    check("rst_data", {24'h0, txfifo_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // basic frame, seq 0
    wr_cyc.delete();
    push5(8'hA5, 8'h00, 8'h10, 8'h20, 8'h95);
    send_pulse(k);
    wait_idle();
    check_frame("basic", k, 4);

    // error flag, seq 1; live phases change mid-frame
    wr_cyc.delete();
    push5(8'hA5, 8'h81, 8'h10, 8'h20, 8'h14);
    read_error = 1'b1;
    send_pulse(k);
    read_error = 1'b0;
    phases     = {8'hEE, 8'hFF};
    wait_idle();
    phases     = {8'h20, 8'h10};
    check_frame("err", k, 4);

    // back-pressure, seq 2
    wr_cyc.delete();
    push5(8'hA5, 8'h02, 8'h10, 8'h20, 8'h97);
    send_pulse(k);
    repeat (3) @(posedge clk);
    #1 txfifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_wr", {31'h0, txfifo_wr}, 32'h0);
      check("stall_data", {24'h0, txfifo_data}, 32'h20);
    end
    @(posedge clk);
    #1 txfifo_full = 1'b0;
    wait_idle();
    check_frame("bp", k, 7);

    // space gating, seq 3
    wr_cyc.delete();
    txfifo_load = 13'd4093;
    push5(8'hA5, 8'h03, 8'h10, 8'h20, 8'h96);
    send_pulse(k);
    repeat (4) begin
      @(negedge clk);
      check("wait_wr", {31'h0, txfifo_wr}, 32'h0);
      check("wait_busy", {31'h0, busy}, 32'h1);
    end
    @(posedge clk);
    #1 txfifo_load = 13'd4091;
    p = cyc;
    wait_idle();
    txfifo_load = '0;
    check_frame("space", p + 1, 4);

    // coalescing: seq 4 then one extra frame seq 5 with ovr
    wr_cyc.delete();
    push5(8'hA5, 8'h04, 8'h10, 8'h20, 8'h91);
    push5(8'hA5, 8'h45, 8'h10, 8'h20, 8'hD0);
    send_pulse(k);
    repeat (3) begin
      send_req = 1'b1;
      @(posedge clk);
      #1 send_req = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_idle();
    check("coal_nwr", wr_cyc.size(), 10);
    if (wr_cyc.size() == 10) begin
      check("coal_first", wr_cyc[0], k);
      check("coal_end1", wr_cyc[4], k + 4);
      check("coal_start2", wr_cyc[5], k + 6);
      check("coal_end2", wr_cyc[9], k + 10);
    end

    // async reset during byte 3 of seq 6
    wr_cyc.delete();
    expq.push_back(8'hA5);
    expq.push_back(8'h06);
    expq.push_back(8'h10);
    send_pulse(k);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_wr", {31'h0, txfifo_wr}, 32'h1);
    check("pre_rst_data", {24'h0, txfifo_data}, 32'h20);
    rst = 1'b1;
    #1;
    check("async_wr", {31'h0, txfifo_wr}, 32'h0);
    check("async_data", {24'h0, txfifo_data}, 32'h0);
    check("async_busy", {31'h0, busy}, 32'h0);
    check("partial_nwr", wr_cyc.size(), 3);
    @(posedge clk);
    #2 rst = 1'b0;

    // seq restarts at 0
    wr_cyc.delete();
    push5(8'hA5, 8'h00, 8'h10, 8'h20, 8'h95);
    send_pulse(k);
    wait_idle();
    check_frame("post_rst", k, 4);

    check("sb_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/transmitter.md
Name: transmitter

Overview:
- FPGA→host status path; counterpart to the command receiver.
- On request, snapshots the current channel phases and an error flag, builds a fixed-length checksummed frame, and writes it byte-by-byte into the proto245 TX FIFO.
- Sits beside the receiver in top, driving txfifo_wr/txfifo_data. The host reads the frame back to confirm what the array is driving.

Parameters:
- NUM_CHANNELS, 2: number of transducer channels reported.
- PHASE_W, 8: phase width; must be ≤ DATA_W. Each phase is zero-extended to one byte.
- DATA_W, 8: TX FIFO data width.
- TX_FIFO_SIZE, 4096: TX FIFO depth in bytes.
- TX_FIFO_LOAD_W, 13: width of txfifo_load, equal to clog2(TX_FIFO_SIZE)+1.
- HEADER, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock (10.24 MHz)
- rst  in  1  asynchronous active-high reset
- send_req  in  1  single-cycle request to emit one frame
- phases  in  [PHASE_W-1:0] x NUM_CHANNELS  live phase values from the receiver
- read_error  in  1  receiver error flag
- txfifo_load  in  TX_FIFO_LOAD_W  TX FIFO occupancy
- txfifo_full  in  1  TX FIFO full
- txfifo_wr  out  1  TX FIFO write strobe
- txfifo_data  out  DATA_W  TX FIFO write data
- busy  out  1  high while not in IDLE

Behaviour:
- Frame layout, FRAME_LEN = NUM_CHANNELS+3 bytes:
  - byte 0: HEADER
  - byte 1: STATUS = {err, ovr, seq[5:0]}
  - bytes 2..NUM_CHANNELS+1: phases[0..N-1]
  - last byte: XOR of all preceding frame bytes
- err: read_error sampled at snapshot.
- ovr: set if any send_req arrived while a request was already pending. Cleared at snapshot.
- seq: 6-bit frame counter. Starts at 0, increments after each completed frame, wraps 63→0.
- Reset (async): state=IDLE, txfifo_wr=0, txfifo_data=0, busy=0, seq=0, pending=0, ovr=0, byte index=0, snapshot regs=0.
- FSM states and transitions:
  - IDLE: on (send_req | pending), snapshot phases/err/ovr into registers and clear pending. Go to SEND if space_ok, else WAIT_SPACE.
  - WAIT_SPACE: stay until space_ok, then go to SEND. No writes.
  - SEND: emit one byte per cycle in which txfifo_full=0. On the last byte write, seq++ and return to IDLE.
- space_ok = (txfifo_load + FRAME_LEN ≤ TX_FIFO_SIZE), evaluated at TX_FIFO_LOAD_W+1 bits. The whole frame is guaranteed room before its first byte, so frames never straddle a long stall.
- Write handshake:
  - txfifo_wr = (state==SEND) & ~txfifo_full. Combinational from registered state.
  - txfifo_data = byte[idx], also driven in cycles where no write occurs.
  - idx advances only on an actual write. If txfifo_full asserts mid-frame, hold idx and data and deassert wr; resume when it clears.
- Latency and throughput:
  - send_req sampled at edge k with space available → first write in cycle k+1.
  - A full frame takes FRAME_LEN cycles with no back-pressure.
  - A pending request causes exactly one idle cycle between frames.
- Requests during busy:
  - send_req while busy and pending=0 → pending=1.
  - send_req while pending=1 → ovr=1; the request is coalesced, not queued.
  - send_req on the same cycle as the IDLE snapshot is consumed by that snapshot.
- The checksum is accumulated from snapshot registers, not live inputs. Phases changing during SEND do not affect the frame.
- Reset mid-frame aborts immediately. Any partial frame already in the FIFO is the host's responsibility; the host resyncs on HEADER plus the checksum.

Decomposition:
- Shared package (shared with the receiver): HEADER, FRAME_LEN function of NUM_CHANNELS, STATUS bit positions, and the FSM state enum tx_state_t {IDLE, WAIT_SPACE, SEND}.
- Sub-module frame_builder (combinational): maps snapshot registers + idx to a byte; includes the XOR reduction.
- FSM, counters and pending logic stay in transmitter.

Test Plan:
- Basic frame: phases={8'h10,8'h20}, read_error=0, empty FIFO, send_req pulse → txfifo_wr high 5 consecutive cycles starting next cycle, bytes A5,00,10,20,95, then busy=0 and seq=1.
- Error and sequence: second request with read_error=1 → bytes A5,81,10,20,14.
- Back-pressure: txfifo_full asserted for 3 cycles after byte 2 is written → wr low, data held at byte 3 for those cycles, frame completes intact, 8 cycles total.
- Space gating: txfifo_load=4093 (only 3 free), send_req → WAIT_SPACE with no writes; drop load to 4091 → frame starts the next cycle.
- Coalescing: three send_req pulses during a frame → exactly one extra frame after a 1-cycle gap, with ovr=1 in its STATUS byte.
- Async reset during byte 3 → outputs 0 immediately without a clock edge; next request sends seq=0.
